// File: rtl/attention_softmax_norm_pkg.sv
// rtl/attention_softmax_norm_pkg.sv - shared constants for the softmax normalisation stage
package attn_softmax_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SUM      = 3'd1;
    localparam logic [2:0] S_NRM_REQ  = 3'd2;
    localparam logic [2:0] S_NRM_WAIT = 3'd3;
    localparam logic [2:0] S_NRM_DIV  = 3'd4;
    localparam logic [2:0] S_ROW_NEXT = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // 1.0 in Q16.16
    localparam logic [31:0] Q16_ONE = 32'h0001_0000;

    // Quotient bits 16..0 produced one per cycle
    localparam int DIV_ITERS = 17;

endpackage

// File: rtl/seq_frac_udiv.sv
// rtl/seq_frac_udiv.sv - 17-step restoring divider returning floor(dividend*2^16/divisor)
module seq_frac_udiv
    import attn_softmax_pkg::*;
#(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic                 busy,
    output logic                 div_done,
    output logic [16:0]          quotient
);

    // One spare bit so the shifted remainder (< 2*divisor) never overflows
    localparam int REM_W = ((DIVIDEND_W > DIVISOR_W) ? DIVIDEND_W : DIVISOR_W) + 1;

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] rem_next;
    logic [REM_W-1:0] dsr_ext;
    logic [DIVISOR_W-1:0] dsr;
    logic [4:0]       iter;
    logic             ge;

    // First step compares the raw dividend (integer bit), later steps shift first
    always_comb begin
        dsr_ext  = {{(REM_W-DIVISOR_W){1'b0}}, dsr};
        rem_sh   = (iter == 5'd0) ? rem : (rem << 1);
        ge       = (rem_sh >= dsr_ext);
        rem_next = ge ? (rem_sh - dsr_ext) : rem_sh;
    end

    // Iteration sequencer: quotient bits shift in MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            div_done <= 1'b0;
            quotient <= '0;
        end else begin
            div_done <= 1'b0;
            if (load) begin
                rem      <= {{(REM_W-DIVIDEND_W){1'b0}}, dividend};
                dsr      <= divisor;
                iter     <= '0;
                busy     <= 1'b1;
                quotient <= '0;
            end else if (busy) begin
                rem      <= rem_next;
                quotient <= {quotient[15:0], ge};
                iter     <= iter + 5'd1;
                if (iter == 5'(DIV_ITERS - 1)) begin
                    busy     <= 1'b0;
                    div_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/attention_softmax_norm.sv
// rtl/attention_softmax_norm.sv - row-wise softmax normalisation of the exp matrix into P
module attention_softmax_norm
    import attn_softmax_pkg::*;
#(
    parameter int T     = 4,
    parameter int T_W   = (T <= 1) ? 1 : $clog2(T),
    parameter int SUM_W = 32 + T_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           exp_done,
    output logic           exp_re,
    output logic [T_W-1:0] exp_tq,
    output logic [T_W-1:0] exp_tk,
    input  logic [31:0]    exp_rdata,
    input  logic           exp_rvalid,
    input  logic           prob_re,
    input  logic [T_W-1:0] prob_tq,
    input  logic [T_W-1:0] prob_tk,
    output logic [31:0]    prob_rdata,
    output logic           prob_rvalid,
    output logic           busy,
    output logic           norm_done
);

    logic [2:0]       state;
    logic [T_W-1:0]   tq;
    logic [T_W-1:0]   tk;
    logic [T_W:0]     iss_cnt;
    logic [T_W:0]     rsp_cnt;
    logic [SUM_W-1:0] sum;
    logic             exp_done_q;
    logic             trigger;
    logic             sum_zero;
    logic             div_load;
    logic             div_busy;
    logic             div_done;
    logic [16:0]      div_q;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [31:0]      prob_mat [T][T];

    // Request/write decode; a zero row is filled without touching the upstream port
    always_comb begin
        trigger  = exp_done & ~exp_done_q;
        sum_zero = (sum == '0);
        exp_re   = ((state == S_SUM) && (iss_cnt < (T_W+1)'(T))) ||
                   ((state == S_NRM_REQ) && !sum_zero);
        exp_tq   = tq;
        exp_tk   = (state == S_SUM) ? iss_cnt[T_W-1:0] : tk;
        div_load = (state == S_NRM_WAIT) && exp_rvalid && !div_busy;
        wr_en    = ((state == S_NRM_REQ) && sum_zero) ||
                   ((state == S_NRM_DIV) && div_done);
        wr_data  = sum_zero ? 32'd0 : {15'd0, div_q};
    end

    seq_frac_udiv #(
        .DIVIDEND_W (32),
        .DIVISOR_W  (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (exp_rdata),
        .divisor  (sum),
        .busy     (div_busy),
        .div_done (div_done),
        .quotient (div_q)
    );

    // Control FSM: sum a row, then divide each entry by the row sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tq         <= '0;
            tk         <= '0;
            iss_cnt    <= '0;
            rsp_cnt    <= '0;
            sum        <= '0;
            exp_done_q <= 1'b0;
            busy       <= 1'b0;
            norm_done  <= 1'b0;
        end else begin
            exp_done_q <= exp_done;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        norm_done <= 1'b0;
                        busy      <= 1'b1;
                        tq        <= '0;
                        tk        <= '0;
                        iss_cnt   <= '0;
                        rsp_cnt   <= '0;
                        sum       <= '0;
                        state     <= S_SUM;
                    end
                end
                S_SUM: begin
                    if (iss_cnt < (T_W+1)'(T)) iss_cnt <= iss_cnt + 1'b1;
                    if (exp_rvalid) begin
                        sum     <= sum + SUM_W'(exp_rdata);
                        rsp_cnt <= rsp_cnt + 1'b1;
                        if (rsp_cnt == (T_W+1)'(T - 1)) begin
                            tk    <= '0;
                            state <= S_NRM_REQ;
                        end
                    end
                end
                S_NRM_REQ: begin
                    if (sum_zero) begin
                        if (tk == T_W'(T - 1)) state <= S_ROW_NEXT;
                        else                   tk    <= tk + 1'b1;
                    end else begin
                        state <= S_NRM_WAIT;
                    end
                end
                S_NRM_WAIT: begin
                    if (div_load) state <= S_NRM_DIV;
                end
                S_NRM_DIV: begin
                    if (div_done) begin
                        if (tk == T_W'(T - 1)) begin
                            state <= S_ROW_NEXT;
                        end else begin
                            tk    <= tk + 1'b1;
                            state <= S_NRM_REQ;
                        end
                    end
                end
                S_ROW_NEXT: begin
                    if (tq == T_W'(T - 1)) begin
                        state <= S_DONE;
                    end else begin
                        tq      <= tq + 1'b1;
                        sum     <= '0;
                        iss_cnt <= '0;
                        rsp_cnt <= '0;
                        state   <= S_SUM;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    norm_done <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // P storage write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en) prob_mat[tq][tk] <= wr_data;
    end

    // Registered read port; same-cycle write is not bypassed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prob_rvalid <= 1'b0;
            prob_rdata  <= '0;
        end else begin
            prob_rvalid <= prob_re;
            prob_rdata  <= prob_re ? prob_mat[prob_tq][prob_tk] : 32'd0;
        end
    end

endmodule

// File: tb/tb_attention_softmax_norm.sv
// tb/tb_attention_softmax_norm.sv - self-checking bench for attention_softmax_norm
module tb_attention_softmax_norm;

    localparam int T   = 4;
    localparam int T_W = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           exp_done;
    logic           exp_re;
    logic [T_W-1:0] exp_tq;
    logic [T_W-1:0] exp_tk;
    logic [31:0]    exp_rdata;
    logic           exp_rvalid;
    logic           prob_re;
    logic [T_W-1:0] prob_tq;
    logic [T_W-1:0] prob_tk;
    logic [31:0]    prob_rdata;
    logic           prob_rvalid;
    logic           busy;
    logic           norm_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [T][T];
    int          re_mon   = 0;
    int          runs_mon = 0;
    logic        busy_d   = 1'b0;

    attention_softmax_norm #(.T(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exp_done    (exp_done),
        .exp_re      (exp_re),
        .exp_tq      (exp_tq),
        .exp_tk      (exp_tk),
        .exp_rdata   (exp_rdata),
        .exp_rvalid  (exp_rvalid),
        .prob_re     (prob_re),
        .prob_tq     (prob_tq),
        .prob_tk     (prob_tk),
        .prob_rdata  (prob_rdata),
        .prob_rvalid (prob_rvalid),
        .busy        (busy),
        .norm_done   (norm_done)
    );

    always #5 clk = ~clk;

    // Upstream exp port model: one-cycle read latency
    always @(posedge clk) begin
        exp_rvalid <= exp_re;
        exp_rdata  <= exp_mem[exp_tq][exp_tk];
    end

    // Monitor: count exp_re cycles and normalisation runs started
    always @(negedge clk) begin
        if (exp_re === 1'b1) re_mon = re_mon + 1;
        if (busy === 1'b1 && busy_d === 1'b0) runs_mon = runs_mon + 1;
        busy_d = busy;
    end

    // Reference: softmax by plain division over the row
    function automatic logic [31:0] ref_p(int r, int c);
        longint s = 0;
        for (int k = 0; k < T; k++) s += longint'(exp_mem[r][k]);
        if (s == 0) return 32'd0;
        return 32'((longint'(exp_mem[r][c]) * 65536) / s);
    endfunction

    // Reference: upstream reads per run (row sum reads, plus entry reads when sum != 0)
    function automatic int ref_reads();
        int n = 0;
        for (int r = 0; r < T; r++) begin
            longint s = 0;
            for (int k = 0; k < T; k++) s += longint'(exp_mem[r][k]);
            n += T + ((s != 0) ? T : 0);
        end
        return n;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++)
                exp_mem[r][c] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    endtask

    task automatic read_p(input int r, input int c, output logic [31:0] d, output logic v);
        @(negedge clk);
        prob_re = 1'b1;
        prob_tq = T_W'(r);
        prob_tk = T_W'(c);
        @(negedge clk);
        prob_re = 1'b0;
        d = prob_rdata;
        v = prob_rvalid;
    endtask

    task automatic run_norm(input string name);
        int base;
        int i;
        base = re_mon;
        exp_done = 1'b0;
        @(negedge clk);
        exp_done = 1'b1;
        @(negedge clk);
        for (i = 0; i < 4000 && norm_done !== 1'b1; i++) @(negedge clk);
        total++;
        if (norm_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout norm_done=%b required 1", name, norm_done);
        end
        total++;
        if (re_mon - base !== ref_reads()) begin
            bad++;
            $display("FAIL %s_exp_reads got %0d required %0d", name, re_mon - base, ref_reads());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exp_done = 1'b0; prob_re = 1'b0; prob_tq = '0; prob_tk = '0;
        exp_rvalid = 1'b0; exp_rdata = '0;
        fill_random();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got %b required 0", busy); end
        total++; if (norm_done !== 1'b0)   begin bad++; $display("FAIL reset_norm_done got %b required 0", norm_done); end
        total++; if (exp_re !== 1'b0)      begin bad++; $display("FAIL reset_exp_re got %b required 0", exp_re); end
        total++; if (prob_rvalid !== 1'b0) begin bad++; $display("FAIL reset_prob_rvalid got %b required 0", prob_rvalid); end
        total++; if (prob_rdata !== 32'd0) begin bad++; $display("FAIL reset_prob_rdata got %h required 0", prob_rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_uniform();
        logic [31:0] d; logic v;
        fill_random();
        for (int c = 0; c < T; c++) exp_mem[0][c] = 32'h0001_0000;
        run_norm("uniform");
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                read_p(r, c, d, v);
                total++;
                if (v !== 1'b1 || d !== ref_p(r, c) || (r == 0 && d !== 32'h0000_4000)) begin
                    bad++;
                    $display("FAIL uniform_p[%0d][%0d] got %h v=%b required %h", r, c, d, v, ref_p(r, c));
                end
            end
    endtask

    task automatic test_ramp();
        logic [31:0] d; logic v;
        logic [31:0] want [T];
        want = '{32'h1999, 32'h3333, 32'h4CCC, 32'h6666};
        fill_random();
        for (int c = 0; c < T; c++) exp_mem[1][c] = 32'((c + 1) * 32'h0001_0000);
        run_norm("ramp");
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                read_p(r, c, d, v);
                total++;
                if (v !== 1'b1 || d !== ref_p(r, c) || (r == 1 && d !== want[c])) begin
                    bad++;
                    $display("FAIL ramp_p[%0d][%0d] got %h v=%b required %h", r, c, d, v, ref_p(r, c));
                end
            end
    endtask

    task automatic test_causal_zero();
        logic [31:0] d; logic v;
        fill_random();
        exp_mem[0] = '{32'h0002_A000, 32'd0, 32'd0, 32'd0};
        exp_mem[3] = '{32'd0, 32'd0, 32'd0, 32'd0};
        run_norm("causal");
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                read_p(r, c, d, v);
                total++;
                if (v !== 1'b1 || d !== ref_p(r, c) ||
                    (r == 0 && d !== ((c == 0) ? 32'h0001_0000 : 32'd0)) ||
                    (r == 3 && d !== 32'd0)) begin
                    bad++;
                    $display("FAIL causal_p[%0d][%0d] got %h v=%b required %h", r, c, d, v, ref_p(r, c));
                end
            end
    endtask

    task automatic test_hold_level();
        int base;
        int i;
        base = runs_mon;
        repeat (50) @(negedge clk);
        total++;
        if (runs_mon - base !== 0) begin bad++; $display("FAIL hold_retrigger runs=%0d required 0", runs_mon - base); end
        total++;
        if (norm_done !== 1'b1) begin bad++; $display("FAIL hold_norm_done got %b required 1", norm_done); end
        fill_random();
        exp_done = 1'b0;
        @(negedge clk);
        exp_done = 1'b1;
        @(negedge clk);
        total++;
        if (norm_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL second_trigger norm_done=%b busy=%b required 0/1", norm_done, busy);
        end
        for (i = 0; i < 4000 && norm_done !== 1'b1; i++) @(negedge clk);
        total++;
        if (norm_done !== 1'b1 || runs_mon - base !== 1) begin
            bad++;
            $display("FAIL second_run norm_done=%b runs=%0d required 1/1", norm_done, runs_mon - base);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        int base;
        int i;
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) exp_mem[r][c] = $urandom | 32'd1;
        base = re_mon;
        exp_done = 1'b0;
        @(negedge clk);
        exp_done = 1'b1;
        // 2 full rows (8 reads each), row 2 sum (4), then first row-2 entry read
        for (i = 0; i < 4000 && (re_mon - base) < 21; i++) @(negedge clk);
        total++;
        if ((re_mon - base) < 21) begin bad++; $display("FAIL midreset_reach reads=%0d required 21", re_mon - base); end
        prob_re = 1'b1; prob_tq = 2'd0; prob_tk = 2'd0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_done = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || norm_done !== 1'b0 || exp_re !== 1'b0 || prob_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs busy=%b done=%b re=%b rvalid=%b required 0", busy, norm_done, exp_re, prob_rvalid);
        end
        prob_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        run_norm("after_reset");
        for (int r = 0; r < T; r++)
            for (int c = 0; c < T; c++) begin
                read_p(r, c, d, v);
                total++;
                if (v !== 1'b1 || d !== ref_p(r, c)) begin
                    bad++;
                    $display("FAIL after_reset_p[%0d][%0d] got %h v=%b required %h", r, c, d, v, ref_p(r, c));
                end
            end
    endtask

    task automatic test_prob_port();
        @(negedge clk);
        prob_re = 1'b1; prob_tq = 2'd1; prob_tk = 2'd2;
        @(negedge clk);
        prob_re = 1'b0;
        total++;
        if (prob_rvalid !== 1'b1 || prob_rdata !== ref_p(1, 2)) begin
            bad++;
            $display("FAIL prob_read got %h v=%b required %h", prob_rdata, prob_rvalid, ref_p(1, 2));
        end
        @(negedge clk);
        total++;
        if (prob_rvalid !== 1'b0 || prob_rdata !== 32'd0) begin
            bad++;
            $display("FAIL prob_idle got %h v=%b required 0", prob_rdata, prob_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_ramp();
        test_causal_zero();
        test_hold_level();
        test_prob_port();
        test_reset_mid();
        test_prob_port();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/attention_softmax_norm.md
Name: attention_softmax_norm

Overview:
- Downstream stage of the exp(SC) producer; consumes the T x T Q16.16 exp matrix through that block's exp read port.
- Produces softmax probabilities P[tq][tk] = exp[tq][tk] / sum_k exp[tq][k] as Q16.16 in [0, 1.0].
- Stores P in a local T x T matrix and exposes a 1-cycle read port to the attention·V stage.
- Starts on the rising edge of the upstream exp_done.

Parameters:
T, 4, sequence length (matrix is T x T)
T_W, derived ((T<=1)?1:$clog2(T)), index width
SUM_W, derived (32+T_W), row-sum accumulator width; cannot overflow

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exp_done  in  1  upstream exp matrix ready (level; held until next upstream start)
exp_re  out  1  read request to upstream exp port
exp_tq  out  T_W  row index for exp read
exp_tk  out  T_W  column index for exp read
exp_rdata  in  32  exp value, Q16.16, unsigned
exp_rvalid  in  1  exp_rdata valid; arrives exactly 1 cycle after exp_re
prob_re  in  1  probability read request
prob_tq  in  T_W  probability row index
prob_tk  in  T_W  probability column index
prob_rdata  out  32  probability, Q16.16
prob_rvalid  out  1  prob_rdata valid, 1 cycle after prob_re
busy  out  1  normalisation in progress
norm_done  out  1  P matrix complete; held until next trigger

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM in S_IDLE; row/column counters 0; exp_done_q 0. prob_mat is not reset.
- Trigger: exp_done & !exp_done_q (edge-registered). A level held high does not re-trigger. On trigger: norm_done<=0, busy<=1, tq<=0.
- A trigger while busy is ignored.
- FSM states:
  - S_IDLE: wait for trigger -> S_SUM.
  - S_SUM: issue exp_re for tk=0..T-1 on T consecutive cycles. Accumulate exp_rdata into a SUM_W-bit sum on each exp_rvalid. When T responses are received -> S_NRM_REQ with tk=0.
  - S_NRM_REQ: if sum==0, write 0 to P[tq][tk] and advance without reading. Otherwise pulse exp_re -> S_NRM_WAIT.
  - S_NRM_WAIT: on exp_rvalid, load the divider with (exp_rdata, sum) -> S_NRM_DIV.
  - S_NRM_DIV: on div_done, write quotient to P[tq][tk]. Then: if tk<T-1, tk++ -> S_NRM_REQ; else -> S_ROW_NEXT.
  - S_ROW_NEXT: if tq==T-1 -> S_DONE; else tq++, clear sum -> S_SUM.
  - S_DONE: busy<=0, norm_done<=1 -> S_IDLE (norm_done stays 1).
- Arithmetic:
  - quotient = floor(e*65536/sum), zero-extended to 32 bits.
  - Since e <= sum, the result is <= 0x0001_0000.
  - A row with one nonzero entry yields exactly 0x0001_0000 for that entry.
- Divider: 17-iteration restoring division, rem initialised to e.
  - Iteration 0 tests rem>=sum and sets quotient bit 16.
  - Iterations 1..16 shift rem left 1, then test and subtract.
  - div_done is asserted 17 cycles after load.
- Timing:
  - Per-row latency, sum!=0: T+1 cycles (sum) + T*(1+1+17+1) cycles.
  - Per-row latency, sum==0: T+1 cycles (sum) + T cycles.
- exp_re is asserted only in S_SUM and S_NRM_REQ, and never for more than one outstanding request during normalisation.
- prob port:
  - prob_rvalid<=prob_re.
  - prob_rdata<=prob_mat[prob_tq][prob_tk] if prob_re, else 0.
  - Reads are allowed while busy and return current contents.
  - A read and an internal write to the same entry in the same cycle returns the old value.
- Reset mid-operation: immediate abort. The next exp_done rising edge restarts from row 0.

Decomposition:
- Package attn_softmax_pkg:
  - FSM state enum (S_IDLE, S_SUM, S_NRM_REQ, S_NRM_WAIT, S_NRM_DIV, S_ROW_NEXT, S_DONE).
  - Q16_ONE = 32'h0001_0000.
  - DIV_ITERS = 17.
- Sub-module seq_frac_udiv (params DIVIDEND_W=32, DIVISOR_W=SUM_W):
  - inputs: load, dividend, divisor.
  - outputs: busy, div_done (1-cycle pulse), quotient[16:0].

Test Plan:
- T=4, row0 exp = four x 0x00010000 -> sum 0x40000; P[0][*] = 0x00004000 each; norm_done rises after all rows.
- Row exp = [0x10000, 0x20000, 0x30000, 0x40000] -> P = 0x1999, 0x3333, 0x4CCC, 0x6666.
- Causal row [0x2A000, 0, 0, 0] -> [0x00010000, 0, 0, 0]. All-zero row -> four zeros; no exp_re issued during its normalise pass.
- exp_done held high 50 cycles after completion -> exactly one normalisation run; a second rising edge -> second run, norm_done drops to 0 on that trigger.
- rst_n low during S_NRM_DIV of row 2 -> busy, norm_done, exp_re, prob_rvalid read 0 immediately. Next exp_done edge recomputes all rows correctly.
- After norm_done, prob_re with (tq=1, tk=2) -> prob_rvalid=1 and correct data next cycle. prob_re=0 -> prob_rdata=0, prob_rvalid=0.
